// File: rtl/param_digit_lock_pkg.sv
// Shared types and sizing helpers for the parametrised digit lock.
package param_digit_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } lock_state_e;

    // Bits needed to index n items; never returns zero.
    function automatic int unsigned width_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lock_btn_edge.sv
// Registered rising-edge detector for one debounced button level.
module lock_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic fire_c
);

    logic btn_q;

    // Button history; cleared on reset so a button held through reset fires once after.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign fire_c = btn_i & ~btn_q;

endmodule

// File: rtl/param_digit_lock.sv
// N-digit programmable code lock with entry editing, failure counting and
// optional timed lockout (enabled by PARAM_DIGIT_LOCK_LOCKOUT_EN).
module param_digit_lock
    import param_digit_lock_pkg::*;
#(
    parameter int unsigned             DIGITS         = 3,
    parameter int unsigned             BASE           = 10,
    parameter int unsigned             DW             = 4,
    parameter logic [DIGITS*DW-1:0]    DEFAULT_CODE   = 12'h123,
    parameter int unsigned             MAX_TRIES      = 3,
    parameter int unsigned             LOCKOUT_CYCLES = 16
) (
    input  logic                                enable,
    input  logic                                rst_btn,
    input  logic                                pos_btn,
    input  logic                                digit_btn,
    input  logic                                confirm,
    input  logic                                enter,
    input  logic                                mode,
    output logic [DIGITS*DW-1:0]                entry_o,
    output logic [width_of(DIGITS)-1:0]         pos_o,
    output logic                                unlocked,
    output logic                                err_o,
    output logic                                locked_out,
    output logic [width_of(MAX_TRIES+1)-1:0]    fail_cnt_o
);

    localparam int unsigned EW = DIGITS * DW;
    localparam int unsigned PW = width_of(DIGITS);
    localparam int unsigned FW = width_of(MAX_TRIES + 1);

    // Reject parameter sets the datapath cannot represent.
    if (DIGITS < 2 || BASE < 2 || BASE > 16 || DW < width_of(BASE) ||
        MAX_TRIES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
        $error("param_digit_lock: illegal parameter set");
    end

    lock_state_e   state_q, state_d;
    logic [EW-1:0] entry_q, entry_d, entry_inc;
    logic [EW-1:0] code_q, code_d;
    logic [PW-1:0] pos_q, pos_d, pos_inc;
    logic [FW-1:0] fail_q, fail_d;
    logic          err_q, err_d;
    logic          unlocked_q, unlocked_d;
    logic          pos_f, digit_f, confirm_f, enter_f;

`ifdef PARAM_DIGIT_LOCK_LOCKOUT_EN
    localparam int unsigned CW = width_of(LOCKOUT_CYCLES);
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          locked_out_q, locked_out_d;
`endif

    lock_btn_edge u_pos_edge   (.clk(enable), .rst_n(rst_btn), .btn_i(pos_btn),   .fire_c(pos_f));
    lock_btn_edge u_digit_edge (.clk(enable), .rst_n(rst_btn), .btn_i(digit_btn), .fire_c(digit_f));
    lock_btn_edge u_conf_edge  (.clk(enable), .rst_n(rst_btn), .btn_i(confirm),   .fire_c(confirm_f));
    lock_btn_edge u_enter_edge (.clk(enable), .rst_n(rst_btn), .btn_i(enter),     .fire_c(enter_f));

    // Cursor advance and wrapping increment of the digit under the cursor.
    always_comb begin
        entry_inc = entry_q;
        pos_inc   = (pos_q == PW'(DIGITS - 1)) ? '0 : pos_q + PW'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (PW'(i) == pos_q) begin
                if (entry_q[i*DW +: DW] == DW'(BASE - 1)) begin
                    entry_inc[i*DW +: DW] = '0;
                end else begin
                    entry_inc[i*DW +: DW] = entry_q[i*DW +: DW] + DW'(1);
                end
            end
        end
    end

    // Next-state logic: highest-priority firing button wins, the rest are dropped.
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        code_d     = code_q;
        pos_d      = pos_q;
        fail_d     = fail_q;
        err_d      = 1'b0;
`ifdef PARAM_DIGIT_LOCK_LOCKOUT_EN
        lock_cnt_d = lock_cnt_q;
`endif
        if (state_q != LOCKOUT) begin
            if (enter_f) begin
                if (state_q == LOCKED) begin
                    entry_d = '0;
                    pos_d   = '0;
                    if (entry_q == code_q) begin
                        state_d = OPEN;
                        fail_d  = '0;
                    end else begin
                        err_d = 1'b1;
`ifdef PARAM_DIGIT_LOCK_LOCKOUT_EN
                        fail_d = fail_q + FW'(1);
                        if (fail_d == FW'(MAX_TRIES)) begin
                            state_d    = LOCKOUT;
                            lock_cnt_d = CW'(LOCKOUT_CYCLES - 1);
                        end
`else
                        if (fail_q != FW'(MAX_TRIES)) begin
                            fail_d = fail_q + FW'(1);
                        end
`endif
                    end
                end else if (!mode) begin
                    state_d = LOCKED;
                    entry_d = '0;
                    pos_d   = '0;
                end
            end else if (confirm_f) begin
                if (state_q == OPEN && mode) begin
                    code_d  = entry_q;
                    entry_d = '0;
                    pos_d   = '0;
                end
            end else if (pos_f) begin
                pos_d = pos_inc;
            end else if (digit_f) begin
                entry_d = entry_inc;
            end
        end
`ifdef PARAM_DIGIT_LOCK_LOCKOUT_EN
        else begin
            if (lock_cnt_q == '0) begin
                state_d = LOCKED;
                fail_d  = '0;
            end else begin
                lock_cnt_d = lock_cnt_q - CW'(1);
            end
        end
        locked_out_d = (state_d == LOCKOUT);
`endif
        unlocked_d = (state_d == OPEN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge enable) begin
        if (!rst_btn) begin
            state_q      <= LOCKED;
            entry_q      <= '0;
            code_q       <= DEFAULT_CODE;
            pos_q        <= '0;
            fail_q       <= '0;
            err_q        <= 1'b0;
            unlocked_q   <= 1'b0;
`ifdef PARAM_DIGIT_LOCK_LOCKOUT_EN
            lock_cnt_q   <= '0;
            locked_out_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            code_q       <= code_d;
            pos_q        <= pos_d;
            fail_q       <= fail_d;
            err_q        <= err_d;
            unlocked_q   <= unlocked_d;
`ifdef PARAM_DIGIT_LOCK_LOCKOUT_EN
            lock_cnt_q   <= lock_cnt_d;
            locked_out_q <= locked_out_d;
`endif
        end
    end

    assign entry_o    = entry_q;
    assign pos_o      = pos_q;
    assign unlocked   = unlocked_q;
    assign err_o      = err_q;
    assign fail_cnt_o = fail_q;
`ifdef PARAM_DIGIT_LOCK_LOCKOUT_EN
    assign locked_out = locked_out_q;
`else
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_param_digit_lock.sv
// Bench for param_digit_lock: behavioural model checked every cycle plus directed literal checks.
module tb_param_digit_lock;

    localparam int          DIGITS = 3;
    localparam int          BASE   = 10;
    localparam int          DW     = 4;
    localparam int          MAXT   = 3;
    localparam int          LOCKC  = 16;
    localparam logic [11:0] DEF    = 12'h123;

    localparam int B_POS = 0, B_DIG = 1, B_CONF = 2, B_ENT = 3;

    logic        enable = 1'b0;
    logic        rst_btn, pos_btn, digit_btn, confirm, enter, mode;
    logic [11:0] entry_o;
    logic [1:0]  pos_o;
    logic        unlocked, err_o, locked_out;
    logic [1:0]  fail_cnt_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    param_digit_lock #(
        .DIGITS(DIGITS), .BASE(BASE), .DW(DW), .DEFAULT_CODE(DEF),
        .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCKC)
    ) dut (
        .enable(enable), .rst_btn(rst_btn), .pos_btn(pos_btn), .digit_btn(digit_btn),
        .confirm(confirm), .enter(enter), .mode(mode), .entry_o(entry_o), .pos_o(pos_o),
        .unlocked(unlocked), .err_o(err_o), .locked_out(locked_out), .fail_cnt_o(fail_cnt_o)
    );

    always #5 enable = ~enable;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: digits as integers, arithmetic wrap, lockout as remaining-clock count.
    int m_dig[DIGITS];
    int m_code[DIGITS];
    int m_pos, m_fails, m_lock_left;
    bit m_open, m_err;
    bit p_pos, p_dig, p_conf, p_ent;

    task automatic model_clear_entry();
        for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
        m_pos = 0;
    endtask

    always @(posedge enable) begin
        bit f_pos, f_dig, f_conf, f_ent, match;
        if (!rst_btn) begin
            model_clear_entry();
            for (int i = 0; i < DIGITS; i++) m_code[i] = (int'(DEF) >> (i*DW)) % 16;
            m_fails = 0; m_lock_left = 0; m_open = 0; m_err = 0;
            p_pos = 0; p_dig = 0; p_conf = 0; p_ent = 0;
        end else begin
            f_pos  = pos_btn   && !p_pos;
            f_dig  = digit_btn && !p_dig;
            f_conf = confirm   && !p_conf;
            f_ent  = enter     && !p_ent;
            p_pos = pos_btn; p_dig = digit_btn; p_conf = confirm; p_ent = enter;
            m_err = 0;
            if (m_lock_left > 0) begin
                m_lock_left--;
                if (m_lock_left == 0) m_fails = 0;
            end else if (f_ent) begin
                if (!m_open) begin
                    match = 1;
                    for (int i = 0; i < DIGITS; i++) if (m_dig[i] != m_code[i]) match = 0;
                    model_clear_entry();
                    if (match) begin
                        m_open = 1; m_fails = 0;
                    end else begin
                        m_err = 1;
`ifdef PARAM_DIGIT_LOCK_LOCKOUT_EN
                        m_fails++;
                        if (m_fails == MAXT) m_lock_left = LOCKC;
`else
                        if (m_fails < MAXT) m_fails++;
`endif
                    end
                end else if (!mode) begin
                    m_open = 0;
                    model_clear_entry();
                end
            end else if (f_conf) begin
                if (m_open && mode) begin
                    for (int i = 0; i < DIGITS; i++) m_code[i] = m_dig[i];
                    model_clear_entry();
                end
            end else if (f_pos) begin
                m_pos = (m_pos + 1) % DIGITS;
            end else if (f_dig) begin
                m_dig[m_pos] = (m_dig[m_pos] + 1) % BASE;
            end
        end
    end

    function automatic logic [11:0] model_entry();
        logic [11:0] e = '0;
        for (int i = 0; i < DIGITS; i++) e[i*DW +: DW] = 4'(m_dig[i]);
        return e;
    endfunction

    // Compare DUT against model on every falling edge once reset has been applied.
    always @(negedge enable) begin
        if (chk_en) begin
            check("model entry_o",    32'(entry_o),    32'(model_entry()));
            check("model pos_o",      32'(pos_o),      32'(m_pos));
            check("model unlocked",   32'(unlocked),   32'(m_open));
            check("model err_o",      32'(err_o),      32'(m_err));
            check("model locked_out", 32'(locked_out), 32'(m_lock_left > 0));
            check("model fail_cnt",   32'(fail_cnt_o), 32'(m_fails));
        end
    end

    task automatic down(input int which);
        case (which)
            B_POS:   pos_btn   = 1'b1;
            B_DIG:   digit_btn = 1'b1;
            B_CONF:  confirm   = 1'b1;
            default: enter     = 1'b1;
        endcase
        @(negedge enable);
    endtask

    task automatic up();
        pos_btn = 0; digit_btn = 0; confirm = 0; enter = 0;
        @(negedge enable);
    endtask

    task automatic press(input int which);
        down(which);
        up();
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2);
        repeat (d0) press(B_DIG);
        press(B_POS);
        repeat (d1) press(B_DIG);
        press(B_POS);
        repeat (d2) press(B_DIG);
    endtask

    initial begin
        int cnt;
        rst_btn = 0; pos_btn = 0; digit_btn = 0; confirm = 0; enter = 0; mode = 0;
        repeat (2) @(negedge enable);
        chk_en = 1'b1;
        check("reset entry", 32'(entry_o), 32'h0);
        check("reset pos", 32'(pos_o), 32'd0);
        check("reset unlocked", 32'(unlocked), 32'd0);
        check("reset fail", 32'(fail_cnt_o), 32'd0);
        rst_btn = 1;
        @(negedge enable);

        // Enter default code 123 and open.
        enter_code(3, 2, 1);
        check("entry 123", 32'(entry_o), 32'h123);
        check("pos 2", 32'(pos_o), 32'd2);
        press(B_ENT);
        check("open unlocked", 32'(unlocked), 32'd1);
        check("open entry clr", 32'(entry_o), 32'h0);

        // Digit wrap, cursor wrap, held button fires once.
        repeat (10) press(B_DIG);
        check("digit wrap", 32'(entry_o), 32'h0);
        repeat (3) press(B_POS);
        check("pos wrap", 32'(pos_o), 32'd0);
        digit_btn = 1;
        repeat (5) @(negedge enable);
        up();
        check("held once", 32'(entry_o), 32'h001);

        // Program 456 and relock.
        mode = 1;
        enter_code(5, 5, 4);
        check("entry 456", 32'(entry_o), 32'h456);
        press(B_CONF);
        check("confirm clr", 32'(entry_o), 32'h0);
        check("confirm still open", 32'(unlocked), 32'd1);
        mode = 0;
        press(B_ENT);
        check("relocked", 32'(unlocked), 32'd0);

        // Old code now fails; new code opens.
        enter_code(3, 2, 1);
        down(B_ENT);
        check("err pulse", 32'(err_o), 32'd1);
        up();
        check("err one cycle", 32'(err_o), 32'd0);
        check("fail 1", 32'(fail_cnt_o), 32'd1);
        enter_code(6, 5, 4);
        press(B_ENT);
        check("new code opens", 32'(unlocked), 32'd1);
        check("fail cleared", 32'(fail_cnt_o), 32'd0);

        // Simultaneous enter+digit in LOCKED: only the check happens.
        press(B_ENT);
        press(B_DIG); press(B_DIG);
        enter = 1; digit_btn = 1;
        @(negedge enable);
        check("prio err", 32'(err_o), 32'd1);
        check("prio entry", 32'(entry_o), 32'h0);
        check("prio fail", 32'(fail_cnt_o), 32'd1);
        up();

        press(B_ENT);
        check("fail 2", 32'(fail_cnt_o), 32'd2);
        down(B_ENT);
        check("fail 3", 32'(fail_cnt_o), 32'd3);
`ifdef PARAM_DIGIT_LOCK_LOCKOUT_EN
        check("lockout on", 32'(locked_out), 32'd1);
        enter = 0;
        cnt = 1;
        for (int k = 0; k < 40 && locked_out; k++) begin
            digit_btn = (k == 0);
            pos_btn   = (k == 2);
            enter     = (k >= 4);
            @(negedge enable);
            if (locked_out) cnt++;
        end
        check("lockout length", 32'(cnt), 32'd16);
        @(negedge enable);
        up();
        check("post lockout fail", 32'(fail_cnt_o), 32'd0);
        check("post lockout entry", 32'(entry_o), 32'h0);
        check("post lockout closed", 32'(unlocked), 32'd0);
`else
        check("no lockout", 32'(locked_out), 32'd0);
        up();
        down(B_ENT);
        check("sat err", 32'(err_o), 32'd1);
        check("sat fail", 32'(fail_cnt_o), 32'd3);
        up();
`endif
        enter_code(6, 5, 4);
        press(B_ENT);
        check("reopen", 32'(unlocked), 32'd1);

        // Reset while OPEN restores default code.
        rst_btn = 0;
        @(negedge enable);
        check("rst unlocked", 32'(unlocked), 32'd0);
        check("rst entry", 32'(entry_o), 32'h0);
        check("rst err", 32'(err_o), 32'd0);
        check("rst locked_out", 32'(locked_out), 32'd0);
        rst_btn = 1;
        @(negedge enable);
        enter_code(3, 2, 1);
        press(B_ENT);
        check("default code back", 32'(unlocked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
